// File: rtl/csk_pkg.sv
// csk_pkg: shared helpers and types for the pipelined carry-skip adder.
// Provides the stage-count function, the parameter legality check and the
// per-stage control payload (valid flag and carry into the next block).
package csk_pkg;

  // Number of pipeline stages: one per skip block.
  function automatic int csk_nstg(input int width, input int block);
    return width / block;
  endfunction

  // Operand width must be a whole, non-zero number of skip blocks.
  function automatic bit csk_params_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

  // Control part of a stage register; the sum and operand slices travel beside it.
  typedef struct packed {
    logic valid;
    logic carry;
  } csk_ctl_t;

endpackage

// File: rtl/csk_block.sv
// csk_block: combinational BLOCK-bit ripple adder with block-propagate detect
// and carry-skip mux. When every bit position propagates, the incoming carry
// bypasses the ripple chain; otherwise the ripple carry-out is used.
module csk_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             p
);

  logic [BLOCK:0] rc;

  // Ripple the carry through the block, producing the sum bits.
  always_comb begin
    rc    = '0;
    sum   = '0;
    rc[0] = c;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ rc[i];
      rc[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc[i]);
    end
  end

  assign p    = &(a ^ b);
  assign cout = p ? c : rc[BLOCK];

endmodule

// File: rtl/csk_adder_pipe.sv
// csk_adder_pipe: pipelined carry-skip adder/subtractor, one skip block per
// stage, valid/ready on both sides with full backpressure (all stages advance
// together or hold together).
// Optional feature: define CSK_OVF_EN to add the 'ovf' output (signed
// two's-complement overflow, registered alongside s).
module csk_adder_pipe
  import csk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
`ifdef CSK_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = csk_nstg(WIDTH, BLOCK);

  if (!csk_params_ok(WIDTH, BLOCK)) begin : g_param_check
    $error("csk_adder_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Stage inputs: stage 0 sees the ports, stage k sees register k-1.
  logic [WIDTH-1:0] in_a   [NSTG];
  logic [WIDTH-1:0] in_b   [NSTG];
  logic             in_c   [NSTG];
  logic [WIDTH-1:0] in_sum [NSTG];
  logic             in_v   [NSTG];

  // Block results and next-state sum words.
  logic [BLOCK-1:0] blk_sum  [NSTG];
  logic             blk_cout [NSTG];
  logic             blk_p    [NSTG];
  logic [WIDTH-1:0] sum_next [NSTG];

  // Stage registers: control, completed lower sum bits, skewed operands.
  csk_ctl_t         ctl_reg [NSTG];
  logic [WIDTH-1:0] sum_reg [NSTG];
  logic [WIDTH-1:0] opa_reg [NSTG];
  logic [WIDTH-1:0] opb_reg [NSTG];

  logic adv;

  assign out_valid = ctl_reg[NSTG-1].valid;
  assign s         = {ctl_reg[NSTG-1].carry, sum_reg[NSTG-1]};
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Route each stage's inputs; subtraction inverts b and forces carry-in.
  always_comb begin
    in_a[0]   = a;
    in_b[0]   = sub ? ~b : b;
    in_c[0]   = sub | cin;
    in_sum[0] = '0;
    in_v[0]   = in_valid;
    for (int k = 1; k < NSTG; k++) begin
      in_a[k]   = opa_reg[k-1];
      in_b[k]   = opb_reg[k-1];
      in_c[k]   = ctl_reg[k-1].carry;
      in_sum[k] = sum_reg[k-1];
      in_v[k]   = ctl_reg[k-1].valid;
    end
  end

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    csk_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .a    (in_a[gi][gi*BLOCK +: BLOCK]),
      .b    (in_b[gi][gi*BLOCK +: BLOCK]),
      .c    (in_c[gi]),
      .sum  (blk_sum[gi]),
      .cout (blk_cout[gi]),
      .p    (blk_p[gi])
    );
  end

  // Merge each block's sum into the partial result word it travels with.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      sum_next[k]                  = in_sum[k];
      sum_next[k][k*BLOCK +: BLOCK] = blk_sum[k];
    end
  end

  // Shift every stage together when the output can advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        ctl_reg[k] <= '0;
        sum_reg[k] <= '0;
        opa_reg[k] <= '0;
        opb_reg[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        ctl_reg[k] <= '{valid: in_v[k], carry: blk_cout[k]};
        sum_reg[k] <= sum_next[k];
        opa_reg[k] <= in_a[k];
        opb_reg[k] <= in_b[k];
      end
    end
  end

  // Signals with no consumer: block-propagate flags (already folded into the
  // skip mux) and operands leaving the final stage.
  logic unused_bits;
  always_comb begin
    unused_bits = ^{opa_reg[NSTG-1], opb_reg[NSTG-1]};
    for (int k = 0; k < NSTG; k++) begin
      unused_bits = unused_bits ^ blk_p[k];
    end
  end

`ifdef CSK_OVF_EN
  // Overflow = carry into MSB xor carry out of MSB, taken in the last stage.
  logic ovf_reg;
  logic ovf_next;

  assign ovf_next = in_a[NSTG-1][WIDTH-1] ^ in_b[NSTG-1][WIDTH-1]
                  ^ blk_sum[NSTG-1][BLOCK-1] ^ blk_cout[NSTG-1];

  // Register overflow in lockstep with the last stage's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (adv) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_csk_adder_pipe.sv
// tb_csk_adder_pipe: scoreboard bench for csk_adder_pipe. Main instance is
// WIDTH=16/BLOCK=4 (directed, backpressure, reset, random traffic); three
// further instances sweep (8,8), (32,4), (64,16) with random traffic.
// With CSK_OVF_EN defined the ovf output is also checked.
module tb_csk_adder_pipe;

  localparam int W    = 16;
  localparam int B    = 4;
  localparam int NSTG = W / B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, sw_rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0]   s;
`ifdef CSK_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Expected responses, {ovf, s}, in issue order.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  logic [W-1:0] ra, rb;
  logic         rc, rs;
  logic [65:0]  res;
  logic         rnd_done;
  int           stale, g;

  csk_adder_pipe #(
    .WIDTH (W),
    .BLOCK (B)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
`ifdef CSK_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Reference: plain modular arithmetic on (w+1)-bit {carry, sum}.
  function automatic logic [65:0] ref_sum(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic sb);
    logic [65:0] full, mask;
    mask = (66'd1 << (w + 1)) - 66'd1;
    if (sb) full = {2'b00, x} - {2'b00, y} + (66'd1 << w);
    else    full = {2'b00, x} + {2'b00, y} + {65'd0, c};
    return full & mask;
  endfunction

  // Reference: signed result outside the w-bit two's-complement range.
  function automatic logic ref_ovf(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic c, input logic sb);
    logic signed [65:0] sx, sy, r, lim;
    sx = $signed({2'b00, x});
    sy = $signed({2'b00, y});
    if (x[w-1]) sx = sx - (66'sd1 <<< w);
    if (y[w-1]) sy = sy - (66'sd1 <<< w);
    r   = sb ? (sx - sy) : (sx + sy + $signed({65'd0, c}));
    lim = 66'sd1 <<< (w - 1);
    return (r >= lim) || (r < -lim);
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation, wait for in_ready, record its expectation.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic ts, input logic [W+1:0] ev);
    int guard;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    exp_q.push_back(ev);
    $display("issue a=0x%04h b=0x%04h cin=%0d sub=%0d exp=0x%05h", ta, tb_, tc, ts, ev[W:0]);
    @(posedge clk);
  endtask

  task automatic send_rand();
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom_range(0, 1));
    rs = 1'($urandom_range(0, 1));
    res = ref_sum(W, 64'(ra), 64'(rb), rc, rs);
    send(ra, rb, rc, rs, {ref_ovf(W, 64'(ra), 64'(rb), rc, rs), res[W:0]});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int gd;
    gd = 0;
    while (exp_q.size() != 0 && gd < 1000) begin
      @(negedge clk);
      gd++;
    end
    chk(name, 66'(exp_q.size()), 66'd0);
  endtask

  // Issue one op into an empty pipe and measure cycles until it is visible.
  task automatic lat_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W+1:0] ev);
    int n;
    send(ta, tb_, tc, ts, ev);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      n++;
    end
    chk("latency", 66'(n), 66'(NSTG));
    @(negedge clk);
    #2;
    chk("valid_one_cycle", 66'(out_valid), 66'd0);
  endtask

  // Monitor: every output handshake pops and compares the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got s=0x%0h, required no output", s);
        end else begin
          mon_e = exp_q.pop_front();
          $display("result s=0x%05h exp=0x%05h", s, mon_e[W:0]);
          chk("result_s", 66'(s), 66'(mon_e[W:0]));
`ifdef CSK_OVF_EN
          chk("result_ovf", 66'(ovf), 66'(mon_e[W+1]));
`endif
        end
      end
    end
  end

  // Parameter sweep instances, each with its own driver and monitor.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
    localparam int SB = (gi == 0) ? 8 : (gi == 1) ? 4 : 16;

    logic          v_in, rdy_in, c_in, sb_in, v_out, rdy_out;
    logic [SW-1:0] xa, xb;
    logic [SW:0]   xs;
`ifdef CSK_OVF_EN
    logic          xo;
`endif
    logic [SW+1:0] q[$];
    logic [SW+1:0] e;
    logic [63:0]   wa, wb;
    logic [65:0]   es;
    bit            done = 1'b0;

    csk_adder_pipe #(
      .WIDTH (SW),
      .BLOCK (SB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (sw_rst_n),
      .in_valid  (v_in),
      .in_ready  (rdy_in),
      .a         (xa),
      .b         (xb),
      .cin       (c_in),
      .sub       (sb_in),
      .out_valid (v_out),
      .out_ready (rdy_out),
      .s         (xs)
`ifdef CSK_OVF_EN
      ,
      .ovf       (xo)
`endif
    );

    initial begin
      int sent, gd;
      bit pend;
      v_in = 1'b0; xa = '0; xb = '0; c_in = 1'b0; sb_in = 1'b0; rdy_out = 1'b1;
      wait (sw_rst_n === 1'b1);
      sent = 0;
      pend = 1'b0;
      while (sent < 1000) begin
        @(negedge clk);
        rdy_out = ($urandom_range(0, 3) != 0);
        if (!pend) begin
          if ($urandom_range(0, 3) != 0) begin
            wa = {$urandom, $urandom};
            wb = {$urandom, $urandom};
            xa = wa[SW-1:0];
            xb = wb[SW-1:0];
            c_in = 1'($urandom_range(0, 1));
            sb_in = 1'($urandom_range(0, 1));
            v_in = 1'b1;
            pend = 1'b1;
          end else begin
            v_in = 1'b0;
          end
        end
        #1;
        if (v_in && rdy_in) begin
          es = ref_sum(SW, 64'(xa), 64'(xb), c_in, sb_in);
          q.push_back({ref_ovf(SW, 64'(xa), 64'(xb), c_in, sb_in), es[SW:0]});
          sent++;
          pend = 1'b0;
        end
      end
      @(negedge clk);
      v_in = 1'b0;
      rdy_out = 1'b1;
      gd = 0;
      while (q.size() != 0 && gd < 1000) begin
        @(negedge clk);
        gd++;
      end
      chk($sformatf("sweep%0d_drain", SW), 66'(q.size()), 66'd0);
      done = 1'b1;
    end

    initial begin
      forever begin
        @(negedge clk);
        #2;
        if (sw_rst_n && v_out && rdy_out) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sweep%0d_unexpected: got s=0x%0h, required no output", SW, xs);
          end else begin
            e = q.pop_front();
            chk($sformatf("sweep%0d_s", SW), 66'(xs), 66'(e[SW:0]));
`ifdef CSK_OVF_EN
            chk($sformatf("sweep%0d_ovf", SW), 66'(xo), 66'(e[SW+1]));
`endif
          end
        end
      end
    end
  end

  // Main stimulus sequence for the 16-bit instance.
  initial begin
    rst_n = 1'b0; sw_rst_n = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rnd_done = 1'b0;
    #1;
    chk("reset_out_valid", 66'(out_valid), 66'd0);
    chk("reset_s", 66'(s), 66'd0);
    chk("reset_in_ready", 66'(in_ready), 66'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sw_rst_n = 1'b1;

    // Latency and single-cycle output pulse.
    lat_op(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 17'h05555});

    // Skip paths, subtraction with borrow, signed overflow.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 17'h10000});
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, {1'b0, 17'h0FFFF});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 17'h0FFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 17'h17FFF});
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, {1'b0, 17'h10000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 17'h08000});
    idle();
    drain("directed_drain");

    // Backpressure: 8 back-to-back ops with a 3-cycle stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #2;
          chk("stall_in_ready", 66'(in_ready), 66'd0);
          chk("stall_out_valid", 66'(out_valid), 66'd1);
          chk("stall_s_held", 66'(s), 66'(exp_q[0][W:0]));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain("backpressure_drain");

    // Reset with three operations in flight and the output stalled.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_reset_out_valid", 66'(out_valid), 66'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 66'(out_valid), 66'd0);
    chk("mid_reset_s", 66'(s), 66'd0);
    chk("mid_reset_in_ready", 66'(in_ready), 66'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", 66'(stale), 66'd0);
    lat_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, {1'b0, 17'h01001});

    // Random traffic with random bubbles and random out_ready.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send_rand();
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");

    g = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("sweep_complete", 66'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 66'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
